// File: rtl/pwm_bank_ctrl.sv
// Bank of NCH independent PWM generators with double-buffered period/duty that
// reload only at period boundaries, SYNC, or while a channel is disabled.
module pwm_lane #(
  parameter int WIDTH = 28
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             en,
  input  logic             center,
  input  logic             pol,
  input  logic             sync,
  input  logic             wr_p,
  input  logic             wr_d,
  input  logic [WIDTH-1:0] wr_data,
  output logic             pwm,
  output logic             pe
);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO = WIDTH'(2);

  logic [WIDTH-1:0] sh_p, sh_d, act_p, act_d, cnt;
  logic             dir_dn;
  logic             short_p, top, terminal;

  always_comb begin
    short_p  = act_p < TWO;
    top      = cnt >= act_p - ONE;
    terminal = 1'b0;
    if (short_p)             terminal = 1'b1;
    else if (center && dir_dn) terminal = cnt <= ONE;
    else if (center)         terminal = top && (act_p == TWO);
    else                     terminal = top;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sh_p   <= '0;
      sh_d   <= '0;
      act_p  <= '0;
      act_d  <= '0;
      cnt    <= '0;
      dir_dn <= 1'b0;
      pwm    <= 1'b0;
      pe     <= 1'b0;
    end else begin
      if (wr_p) sh_p <= wr_data;
      if (wr_d) sh_d <= wr_data;
      pwm <= en ? ((cnt < act_d) ^ pol) : pol;
      // SYNC truncates the period, so it suppresses the end strobe
      pe  <= en & terminal & ~sync;
      if (!en || sync || terminal) begin
        cnt    <= '0;
        dir_dn <= 1'b0;
        act_p  <= sh_p;
        act_d  <= sh_d;
      end else if (center && dir_dn) begin
        cnt <= cnt - ONE;
      end else if (center && top) begin
        dir_dn <= 1'b1;
        cnt    <= cnt - ONE;
      end else begin
        // also the centre->edge recovery path: resume counting upward
        dir_dn <= 1'b0;
        cnt    <= cnt + ONE;
      end
    end
  end
endmodule

module pwm_bank_ctrl #(
  parameter  int NCH   = 8,
  parameter  int WIDTH = 28,
  localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [NCH-1:0]   EN,
  input  logic [NCH-1:0]   CENTER,
  input  logic [NCH-1:0]   POL,
  input  logic             SYNC,
  input  logic             WR,
  input  logic [CH_W-1:0]  WR_CH,
  input  logic             WR_SEL,
  input  logic [WIDTH-1:0] WR_DATA,
  output logic [NCH-1:0]   PWM_OUT,
  output logic [NCH-1:0]   PERIOD_END
);
  logic [NCH-1:0] wr_p, wr_d;

  // indices >= NCH never match any lane, so such writes are dropped
  for (genvar i = 0; i < NCH; i++) begin : g_lane
    assign wr_p[i] = WR && !WR_SEL && (WR_CH == CH_W'(i));
    assign wr_d[i] = WR &&  WR_SEL && (WR_CH == CH_W'(i));

    pwm_lane #(.WIDTH(WIDTH)) u_lane (
      .CLK     (CLK),
      .RST     (RST),
      .en      (EN[i]),
      .center  (CENTER[i]),
      .pol     (POL[i]),
      .sync    (SYNC),
      .wr_p    (wr_p[i]),
      .wr_d    (wr_d[i]),
      .wr_data (WR_DATA),
      .pwm     (PWM_OUT[i]),
      .pe      (PERIOD_END[i])
    );
  end
endmodule

// File: tb/tb_pwm_bank_ctrl.sv
// Directed bench for pwm_bank_ctrl: phase-based reference model checked every
// cycle, plus literal waveform expectations for the key scenarios.
module tb_pwm_bank_ctrl;
  localparam int NCH   = 5;
  localparam int WIDTH = 16;
  localparam int CH_W  = $clog2(NCH);

  logic             CLK = 1'b0;
  logic             RST;
  logic [NCH-1:0]   EN, CENTER, POL;
  logic             SYNC, WR, WR_SEL;
  logic [CH_W-1:0]  WR_CH;
  logic [WIDTH-1:0] WR_DATA;
  logic [NCH-1:0]   PWM_OUT, PERIOD_END;

  int checks = 0;
  int errors = 0;

  pwm_bank_ctrl #(.NCH(NCH), .WIDTH(WIDTH)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .CENTER(CENTER), .POL(POL), .SYNC(SYNC),
    .WR(WR), .WR_CH(WR_CH), .WR_SEL(WR_SEL), .WR_DATA(WR_DATA),
    .PWM_OUT(PWM_OUT), .PERIOD_END(PERIOD_END)
  );

  always #5 CLK = ~CLK;

  // Model: each channel tracks its phase k inside a period of length L;
  // the counter value is derived from k (triangle in centre mode).
  int unsigned    m_shp[NCH], m_shd[NCH], m_ap[NCH], m_ad[NCH], m_k[NCH];
  logic [NCH-1:0] e_pwm, e_pe;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NCH; i++) begin
        m_shp[i] = 0; m_shd[i] = 0; m_ap[i] = 0; m_ad[i] = 0; m_k[i] = 0;
      end
      e_pwm = '0;
      e_pe  = '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        int unsigned len, c;
        bit last;
        len  = (m_ap[i] < 2) ? 1 : (CENTER[i] ? 2*m_ap[i]-2 : m_ap[i]);
        c    = (m_ap[i] < 2) ? 0 : ((m_k[i] < m_ap[i]) ? m_k[i] : 2*m_ap[i]-2-m_k[i]);
        last = (m_k[i] >= len-1);
        e_pwm[i] = EN[i] ? ((c < m_ad[i]) ^ POL[i]) : POL[i];
        e_pe[i]  = EN[i] && last && !SYNC;
        if (!EN[i] || SYNC || last) begin
          m_k[i] = 0; m_ap[i] = m_shp[i]; m_ad[i] = m_shd[i];
        end else m_k[i] = m_k[i] + 1;
      end
      if (WR && (int'(WR_CH) < NCH)) begin
        if (WR_SEL) m_shd[WR_CH] = WR_DATA;
        else        m_shp[WR_CH] = WR_DATA;
      end
    end
  end

  always @(posedge CLK) begin
    #1;
    if (!RST) begin
      checks++;
      if (PWM_OUT !== e_pwm) begin
        errors++;
        $display("FAIL model_pwm t=%0t got=%b exp=%b", $time, PWM_OUT, e_pwm);
      end
      checks++;
      if (PERIOD_END !== e_pe) begin
        errors++;
        $display("FAIL model_pe t=%0t got=%b exp=%b", $time, PERIOD_END, e_pe);
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic wr(input int ch, input logic sel, input int data);
    @(negedge CLK);
    WR = 1'b1; WR_CH = CH_W'(ch); WR_SEL = sel; WR_DATA = WIDTH'(data);
    @(negedge CLK);
    WR = 1'b0;
  endtask

  task automatic sync_pulse();
    @(negedge CLK); SYNC = 1'b1;
    @(negedge CLK); SYNC = 1'b0;
  endtask

  logic [63:0] smp_pw[NCH], smp_pe[NCH];

  // Capture n output samples; optionally write duty of ch after sample wr_after
  task automatic sample_run(input int n, input int wr_after, input int ch, input int data);
    for (int i = 0; i < NCH; i++) begin smp_pw[i] = '0; smp_pe[i] = '0; end
    for (int j = 0; j < n; j++) begin
      @(posedge CLK); #1;
      for (int i = 0; i < NCH; i++) begin
        smp_pw[i][j] = PWM_OUT[i];
        smp_pe[i][j] = PERIOD_END[i];
      end
      if (j == wr_after) begin
        WR = 1'b1; WR_CH = CH_W'(ch); WR_SEL = 1'b1; WR_DATA = WIDTH'(data);
      end else WR = 1'b0;
    end
  endtask

  function automatic int pop(input logic [63:0] v);
    int s = 0;
    for (int j = 0; j < 64; j++) s += int'(v[j]);
    return s;
  endfunction

  function automatic int rises_cyc(input logic [63:0] v, input int n);
    int r = 0;
    for (int j = 0; j < n; j++) if (!v[(j+n-1)%n] && v[j]) r++;
    return r;
  endfunction

  initial begin
    RST = 1'b1; EN = '0; CENTER = '0; POL = '0; SYNC = 1'b0;
    WR = 1'b0; WR_CH = '0; WR_SEL = 1'b0; WR_DATA = '0;
    #3;
    chk("reset_pwm", 64'(PWM_OUT), 64'h0);
    chk("reset_pe", 64'(PERIOD_END), 64'h0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;

    wr(0, 0, 10); wr(0, 1, 3);
    wr(1, 0, 6);  wr(1, 1, 2);
    wr(2, 0, 10); wr(2, 1, 0);
    wr(3, 0, 10); wr(3, 1, 10);
    wr(4, 0, 1);  wr(4, 1, 1);
    wr(6, 0, 5);  wr(6, 1, 5);
    @(negedge CLK); CENTER = 5'b00010; EN = '1;
    repeat (5) @(negedge CLK);

    sample_run(20, -1, 0, 0);
    chk("edge_hi", 64'(pop(smp_pw[0])), 64'd6);
    chk("edge_pe", 64'(pop(smp_pe[0])), 64'd2);
    chk("edge_pe_on_low", smp_pe[0] & smp_pw[0], 64'h0);
    chk("ctr_hi", 64'(pop(smp_pw[1])), 64'd6);
    chk("ctr_pe", 64'(pop(smp_pe[1])), 64'd2);
    chk("ctr_contig", 64'(rises_cyc(smp_pw[1], 10)), 64'd1);
    chk("d0_const0", smp_pw[2], 64'h0);
    chk("dfull_const1", smp_pw[3], 64'hFFFFF);
    chk("p1_const1", smp_pw[4], 64'hFFFFF);
    chk("p1_pe_every", smp_pe[4], 64'hFFFFF);

    @(negedge CLK); POL = '1;
    repeat (2) @(negedge CLK);
    sample_run(20, -1, 0, 0);
    chk("pol_edge_hi", 64'(pop(smp_pw[0])), 64'd14);
    chk("pol_d0", smp_pw[2], 64'hFFFFF);
    chk("pol_dfull", smp_pw[3], 64'h0);
    chk("pol_p1", smp_pw[4], 64'h0);

    @(negedge CLK); EN = '0;
    repeat (2) @(negedge CLK);
    chk("dis_pol1", 64'(PWM_OUT), 64'h1F);
    chk("dis_pe", 64'(PERIOD_END), 64'h0);
    POL = '0;
    repeat (2) @(negedge CLK);
    chk("dis_pol0", 64'(PWM_OUT), 64'h0);

    // ch1 becomes edge P=7 D=2 while disabled, then free-run and SYNC
    wr(1, 0, 7); wr(1, 1, 2);
    @(negedge CLK); CENTER = '0; EN = '1;
    repeat (13) @(negedge CLK);
    sync_pulse();
    sample_run(20, -1, 0, 0);
    chk("sync_ch0_pw", smp_pw[0], 64'h01C07);
    chk("sync_ch0_pe", smp_pe[0], 64'h80200);
    chk("sync_ch1_pw", smp_pw[1], 64'h0C183);
    chk("sync_ch1_pe", smp_pe[1], 64'h02040);

    sync_pulse();
    sample_run(20, 3, 0, 7);
    chk("midwr_d7", smp_pw[0], 64'h1FC07);

    sync_pulse();
    sample_run(30, 8, 0, 2);
    chk("termwr_d2", smp_pw[0], 64'h31FC7F);

    @(negedge CLK); POL = 5'b00100;
    repeat (3) @(negedge CLK);
    @(posedge CLK); #3;
    chk("pre_rst_pol", 64'(PWM_OUT[2]), 64'h1);
    RST = 1'b1;
    #1;
    chk("rst_async_pwm", 64'(PWM_OUT), 64'h0);
    chk("rst_async_pe", 64'(PERIOD_END), 64'h0);
    @(negedge CLK); RST = 1'b0; POL = '0;
    repeat (3) @(negedge CLK);
    for (int j = 0; j < 10; j++) begin
      @(negedge CLK);
      chk("post_rst_pwm", 64'(PWM_OUT), 64'h0);
      chk("post_rst_pe", 64'(PERIOD_END), 64'h1F);
    end

    repeat (2) @(negedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
